// File: rtl/tpx3_rx_lane_arbiter.sv
// Round-robin merge of the Timepix3 per-lane RX FIFOs into one tagged word stream.
// Drains up to MAX_BURST words per grant, honours lane enables and output backpressure.
module tpx3_rx_lane_arbiter #(
    parameter int NUM_LANES  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int LANE_W     = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_LANES-1:0]            LANE_EN,
    input  logic [NUM_LANES-1:0]            LANE_EMPTY,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] LANE_DATA,
    output logic [NUM_LANES-1:0]            LANE_READ,
    output logic [DATA_WIDTH-1:0]           OUT_DATA,
    output logic [LANE_W-1:0]               OUT_LANE,
    output logic                            OUT_VALID,
    input  logic                            OUT_READY,
    input  logic                            CNT_CLEAR,
    output logic [31:0]                     WORD_CNT,
    output logic                            BUSY
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state;
    logic [NUM_LANES-1:0]    req;
    logic [NUM_LANES-1:0]    sel_oh;
    logic [NUM_LANES-1:0]    pick_oh;
    logic [LANE_W-1:0]       sel;
    logic [LANE_W-1:0]       last;
    logic [LANE_W-1:0]       pick;
    logic                    found;
    logic                    can_load;
    logic                    req_sel;
    logic                    rd;
    logic [7:0]              burst_cnt;
    logic [DATA_WIDTH-1:0]   sel_word;
    logic [31:0]             word_cnt;

    assign req      = LANE_EN & ~LANE_EMPTY;
    assign can_load = ~OUT_VALID | OUT_READY;
    assign req_sel  = |(req & sel_oh);
    assign rd       = (state == BURST) & req_sel & can_load;
    assign LANE_READ = rd ? sel_oh : '0;
    assign WORD_CNT = word_cnt;

    // Search starts just after the last granted lane so every lane gets a turn.
    always_comb begin
        int j;
        j       = 0;
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            j = (int'(last) + k) % NUM_LANES;
            if (!found && req[j]) begin
                found   = 1'b1;
                pick    = LANE_W'(j);
                pick_oh = NUM_LANES'(1) << j;
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel_oh[i]) begin
                sel_word = sel_word | LANE_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            sel       <= '0;
            sel_oh    <= NUM_LANES'(1);
            last      <= LANE_W'(NUM_LANES - 1);
            burst_cnt <= '0;
            OUT_DATA  <= '0;
            OUT_LANE  <= '0;
            OUT_VALID <= 1'b0;
            word_cnt  <= '0;
            BUSY      <= 1'b0;
        end else begin
            if (rd) begin
                OUT_DATA  <= sel_word;
                OUT_LANE  <= sel;
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end

            if (CNT_CLEAR) begin
                word_cnt <= '0;
            end else if (rd) begin
                word_cnt <= word_cnt + 32'd1;
            end

            unique case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BURST;
                        sel       <= pick;
                        sel_oh    <= pick_oh;
                        last      <= pick;
                        burst_cnt <= '0;
                        BUSY      <= 1'b1;
                    end
                end
                BURST: begin
                    // An empty or disabled lane ends the burst at once.
                    if (!req_sel || (rd && burst_cnt == 8'(MAX_BURST - 1))) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (rd) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpx3_rx_lane_arbiter.sv
// Bench for tpx3_rx_lane_arbiter: FIFO models, round-robin reference, scoreboard monitor.
// Inputs change on the falling edge; outputs are sampled a few ns after it.
module tb_tpx3_rx_lane_arbiter;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    lane_en;
    logic [N-1:0]    lane_empty;
    logic [N*DW-1:0] lane_data;
    logic [N-1:0]    lane_read;
    logic [DW-1:0]   out_data;
    logic [LW-1:0]   out_lane;
    logic            out_valid;
    logic            out_ready;
    logic            cnt_clear;
    logic [31:0]     word_cnt;
    logic            busy;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0]    lane_q[N][$];
    logic [LW+DW-1:0] sb[$];
    logic [31:0]      exp_cnt;
    int               m_last;
    int               ready_mode;

    tpx3_rx_lane_arbiter #(
        .NUM_LANES(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .LANE_W(LW)
    ) dut (
        .CLK(clk), .RST(rst), .LANE_EN(lane_en), .LANE_EMPTY(lane_empty),
        .LANE_DATA(lane_data), .LANE_READ(lane_read), .OUT_DATA(out_data),
        .OUT_LANE(out_lane), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .CNT_CLEAR(cnt_clear), .WORD_CNT(word_cnt), .BUSY(busy)
    );

    always #5 clk = ~clk;

    function automatic void drive_lanes();
        for (int i = 0; i < N; i++) begin
            lane_empty[i] = (lane_q[i].size() == 0);
            lane_data[i*DW +: DW] = lane_empty[i] ? '0 : lane_q[i][0];
        end
    endfunction

    function automatic bit all_en_empty();
        bit r = 1'b1;
        for (int i = 0; i < N; i++)
            if (lane_en[i] && lane_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    // Reference: static lane contents drained in round-robin turns of at most MB words.
    function automatic void model_drain();
        int cnt[N];
        int idx[N];
        int left = 0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = lane_en[i] ? lane_q[i].size() : 0;
            idx[i] = 0;
            left += cnt[i];
        end
        while (left > 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (cnt[j] > 0) begin
                    int take;
                    take = (cnt[j] < MB) ? cnt[j] : MB;
                    for (int t = 0; t < take; t++)
                        sb.push_back({LW'(j), lane_q[j][idx[j] + t]});
                    idx[j] += take;
                    cnt[j] -= take;
                    left -= take;
                    exp_cnt += 32'(take);
                    m_last = j;
                    break;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane FIFO models: pop on the edge where the strobe was seen.
    initial begin
        logic [N-1:0] rd_s;
        forever begin
            @(negedge clk);
            #2;
            rd_s = lane_read;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (rd_s[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
            drive_lanes();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops plus per-cycle protocol checks.
    initial begin
        bit               stall = 1'b0;
        logic [DW-1:0]    p_data;
        logic [LW-1:0]    p_lane;
        logic [LW+DW-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                stall = 1'b0;
                continue;
            end
            if (lane_read != '0) begin
                tests++;
                if (!$onehot(lane_read) || (lane_read & ~(lane_en & ~lane_empty)) != '0
                    || (out_valid && !out_ready)) begin
                    fails++;
                    $display("FAIL lane_read_legal: got %b en %b empty %b", lane_read,
                             lane_en, lane_empty);
                end
            end
            if (stall) begin
                tests++;
                if (!out_valid || out_data !== p_data || out_lane !== p_lane) begin
                    fails++;
                    $display("FAIL stall_hold: got v%0b %0h/%0d expected %0h/%0d",
                             out_valid, out_data, out_lane, p_data, p_lane);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got %0h lane %0d expected none",
                             out_data, out_lane);
                end else begin
                    e = sb.pop_front();
                    if ({out_lane, out_data} !== e) begin
                        fails++;
                        $display("FAIL out_word: got %0d:%0h expected %0d:%0h",
                                 out_lane, out_data, e[LW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end
            stall  = out_valid && !out_ready;
            p_data = out_data;
            p_lane = out_lane;
        end
    end

    task automatic wait_drain(input int bound);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < bound) begin
            @(negedge clk);
            #4;
            done = (sb.size() == 0) && !out_valid && !busy && all_en_empty();
            n++;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        check("word_cnt", 64'(word_cnt), 64'(exp_cnt));
    endtask

    task automatic wait_sig(input string name, input int which, input int bound);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < bound) begin
            @(negedge clk);
            #2;
            hit = (which < 0) ? out_valid : lane_read[which];
            n++;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL %s: got timeout expected event", name);
        end
    endtask

    task automatic load(input int lane, input int cnt);
        for (int i = 0; i < cnt; i++) lane_q[lane].push_back($urandom);
    endtask

    initial begin
        rst = 1'b1; lane_en = '1; cnt_clear = 1'b0;
        ready_mode = 0; out_ready = 1'b1;
        exp_cnt = '0; m_last = N - 1;
        drive_lanes();
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 0);
        check("rst_data", 64'(out_data), 0);
        check("rst_lane", 64'(out_lane), 0);
        check("rst_cnt", 64'(word_cnt), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_read", 64'(lane_read), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single lane, two words: exact latency.
        load(3, 2);
        drive_lanes();
        model_drain();
        #2;
        check("lat_c0_read", 64'(lane_read), 0);
        @(negedge clk); #2;
        check("lat_c1_read", 64'(lane_read), 64'h08);
        check("lat_c1_valid", 64'(out_valid), 0);
        @(negedge clk); #2;
        check("lat_c2_valid", 64'(out_valid), 1);
        check("lat_c2_lane", 64'(out_lane), 3);
        wait_drain(50);

        // Three lanes of six words: bursts of four then two.
        load(0, 6); load(1, 6); load(2, 6);
        drive_lanes();
        model_drain();
        wait_drain(100);

        // Stall after the first word of lane 5.
        load(5, 4);
        drive_lanes();
        model_drain();
        wait_sig("stall_first", -1, 20);
        ready_mode = 2;
        repeat (3) @(negedge clk);
        ready_mode = 0;
        wait_drain(50);

        // Lane 2 disabled after its first pop while lane 6 waits.
        load(2, 4);
        drive_lanes();
        sb.push_back({LW'(2), lane_q[2][0]});
        wait_sig("dis_first_read", 2, 20);
        @(negedge clk);
        lane_en[2] = 1'b0;
        load(6, 2);
        drive_lanes();
        sb.push_back({LW'(6), lane_q[6][0]});
        sb.push_back({LW'(6), lane_q[6][1]});
        exp_cnt += 32'd3;
        m_last = 6;
        wait_drain(50);
        check("dis_left", 64'(lane_q[2].size()), 3);
        lane_q[2].delete();
        lane_en = '1;
        drive_lanes();

        // Pending word drains while every lane is disabled.
        ready_mode = 2;
        @(negedge clk);
        load(3, 1);
        drive_lanes();
        model_drain();
        wait_sig("alloff_first", -1, 20);
        @(negedge clk);
        lane_en = '0;
        for (int i = 0; i < N; i++) load(i, 1);
        drive_lanes();
        ready_mode = 0;
        wait_drain(30);
        repeat (5) @(negedge clk);
        #4;
        check("alloff_busy", 64'(busy), 0);
        check("alloff_kept", 64'(lane_q[0].size() + lane_q[5].size()), 2);
        for (int i = 0; i < N; i++) lane_q[i].delete();
        lane_en = '1;
        drive_lanes();
        @(negedge clk);

        // Counter wrap, then clear coinciding with a pop.
        force dut.word_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.word_cnt;
        #1;
        check("cnt_forced", 64'(word_cnt), 64'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        load(4, 1);
        drive_lanes();
        model_drain();
        wait_drain(30);
        @(negedge clk);
        load(4, 2);
        drive_lanes();
        model_drain();
        repeat (2) @(negedge clk);
        cnt_clear = 1'b1;
        #2;
        check("clr_read", 64'(lane_read), 64'h10);
        @(negedge clk);
        cnt_clear = 1'b0;
        #1;
        check("clr_cnt", 64'(word_cnt), 0);
        exp_cnt = '0;
        wait_drain(30);

        // Random contents, enables and backpressure.
        for (int it = 0; it < 12; it++) begin
            @(negedge clk);
            ready_mode = 1;
            lane_en = N'($urandom);
            for (int i = 0; i < N; i++) load(i, $urandom_range(0, 6));
            drive_lanes();
            model_drain();
            wait_drain(400);
            for (int i = 0; i < N; i++) lane_q[i].delete();
            drive_lanes();
        end
        lane_en = '1;

        // Reset while a word sits stalled in the output register.
        ready_mode = 2;
        @(negedge clk);
        load(1, 4);
        drive_lanes();
        wait_sig("rst_first", -1, 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 0);
        check("mid_rst_read", 64'(lane_read), 0);
        check("mid_rst_cnt", 64'(word_cnt), 0);
        check("mid_rst_lost", 64'(lane_q[1].size()), 3);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        m_last = N - 1;
        ready_mode = 1;
        load(5, 2);
        load(0, 1);
        drive_lanes();
        model_drain();
        wait_drain(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
